// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for two producers (ALU, load unit) onto one register-file write port,
// plus a pending-write scoreboard that flags read-after-write hazards for the issue stage.
module rf_wb_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic [31:0]     busy,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd
);

  logic            prio_q, prio_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_a3_q, rf_a3_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic [31:0]     busy_q, busy_d;

  logic            gnt0, gnt1;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // Port always accepts; a lone requester wins, otherwise prio decides. Nothing is granted in reset.
  always_comb begin
    gnt0    = rst_n & req0_valid & (~req1_valid | ~prio_q);
    gnt1    = rst_n & req1_valid & (~req0_valid | prio_q);
    wb_rd   = gnt1 ? req1_rd : req0_rd;
    wb_data = gnt1 ? req1_data : req0_data;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // A write-back latched just before reset must not reach the register file.
  assign rf_we = rf_we_q & rst_n;
  assign rf_a3 = rf_a3_q;
  assign rf_wd = rf_wd_q;
  assign busy  = busy_q;

  always_comb begin
    prio_d  = prio_q;
    rf_we_d = 1'b0;
    rf_a3_d = rf_a3_q;
    rf_wd_d = rf_wd_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
    if (gnt0 || gnt1) begin
      rf_we_d = (wb_rd != 5'd0);
      rf_a3_d = wb_rd;
      rf_wd_d = wb_data;
    end
  end

  // Clear first so that a same-cycle issue to the committing register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we) begin
      busy_d[rf_a3_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    hazard = ((chk_rs1 != 5'd0) && busy_q[chk_rs1]) ||
             ((chk_rs2 != 5'd0) && busy_q[chk_rs2]) ||
             (iss_valid && (iss_rd != 5'd0) && busy_q[iss_rd]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q  <= 1'b0;
      rf_we_q <= 1'b0;
      rf_a3_q <= 5'd0;
      rf_wd_q <= '0;
      busy_q  <= '0;
    end else begin
      prio_q  <= prio_d;
      rf_we_q <= rf_we_d;
      rf_a3_q <= rf_a3_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
    end
  end

endmodule
